tilt_angle_filter: RTL and testbench



---
 rtl/tilt_angle_filter_if.sv | 21 ++
 rtl/tilt_angle_filter.sv | 125 ++++++++++++
 tb/tb_tilt_angle_filter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tilt_angle_filter_if.sv
// Sample/angle bundle between the accelerometer front end and the tilt filter.
// The master side delivers raw samples; the slave side returns the angle bytes.
interface tilt_angle_filter_if;
  logic        sample_valid;
  logic [15:0] accel_x;
  logic [15:0] accel_y;
  logic [7:0]  angle_x;
  logic [7:0]  angle_y;
  logic        angle_valid;
  logic        stale;

  modport master (
    output sample_valid, accel_x, accel_y,
    input  angle_x, angle_y, angle_valid, stale
  );

  modport slave (
    input  sample_valid, accel_x, accel_y,
    output angle_x, angle_y, angle_valid, stale
  );
endinterface

// File: rtl/tilt_angle_filter.sv
// Block-averages signed accelerometer samples per axis and maps them to angle bytes around
// CENTER, with a watchdog that returns the outputs to CENTER when samples stop arriving.
module tilt_angle_filter #(
  parameter int unsigned AVG_LOG2       = 3,
  parameter int unsigned SCALE_SHIFT    = 7,
  parameter logic [7:0]  CENTER         = 8'd135,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input logic                clk,
  input logic                rst,
  tilt_angle_filter_if.slave bus
);

  localparam int unsigned AccW   = 16 + AVG_LOG2;
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0]   TimerMax  = TimerW'(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0]   TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [AVG_LOG2-1:0] CountLast = '1;

  logic signed [AccW-1:0] acc_x_q, acc_y_q;
  logic signed [AccW-1:0] sum_x, sum_y;
  logic [AVG_LOG2-1:0]    count_q;
  logic signed [15:0]     avg_x_q, avg_y_q;
  logic                   s1_valid_q;
  logic [7:0]             sat_x_q, sat_y_q;
  logic                   s2_valid_q;
  logic [7:0]             angle_x_q, angle_y_q;
  logic                   angle_valid_q;
  logic                   stale_q;
  logic [TimerW-1:0]      timer_q;
  logic                   block_end;
  logic                   expire;

  // Scale, offset around CENTER and clamp into the unsigned byte range.
  function automatic logic [7:0] sat_angle(logic signed [15:0] avg);
    logic signed [15:0] scaled;
    logic signed [17:0] sum;
    scaled = avg >>> SCALE_SHIFT;
    sum    = $signed({10'd0, CENTER}) + 18'(scaled);
    if (sum < 18'sd0) begin
      return 8'd0;
    end else if (sum > 18'sd255) begin
      return 8'hff;
    end else begin
      return sum[7:0];
    end
  endfunction

  always_comb begin
    sum_x     = acc_x_q + AccW'($signed(bus.accel_x));
    sum_y     = acc_y_q + AccW'($signed(bus.accel_y));
    block_end = bus.sample_valid && (count_q == CountLast);
    // A sample arriving on the expiry cycle keeps the data alive.
    expire    = !bus.sample_valid && (timer_q == TimerLast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_x_q       <= '0;
      acc_y_q       <= '0;
      count_q       <= '0;
      avg_x_q       <= '0;
      avg_y_q       <= '0;
      s1_valid_q    <= 1'b0;
      sat_x_q       <= '0;
      sat_y_q       <= '0;
      s2_valid_q    <= 1'b0;
      angle_x_q     <= CENTER;
      angle_y_q     <= CENTER;
      angle_valid_q <= 1'b0;
      stale_q       <= 1'b1;
      timer_q       <= '0;
    end else begin
      if (bus.sample_valid) begin
        timer_q <= '0;
      end else if (timer_q != TimerMax) begin
        timer_q <= timer_q + TimerW'(1);
      end

      if (expire) begin
        acc_x_q       <= '0;
        acc_y_q       <= '0;
        count_q       <= '0;
        s1_valid_q    <= 1'b0;
        s2_valid_q    <= 1'b0;
        angle_x_q     <= CENTER;
        angle_y_q     <= CENTER;
        angle_valid_q <= 1'b0;
        stale_q       <= 1'b1;
      end else begin
        if (block_end) begin
          avg_x_q <= 16'(sum_x >>> AVG_LOG2);
          avg_y_q <= 16'(sum_y >>> AVG_LOG2);
          acc_x_q <= '0;
          acc_y_q <= '0;
          count_q <= '0;
        end else if (bus.sample_valid) begin
          acc_x_q <= sum_x;
          acc_y_q <= sum_y;
          count_q <= count_q + AVG_LOG2'(1);
        end
        s1_valid_q <= block_end;

        if (s1_valid_q) begin
          sat_x_q <= sat_angle(avg_x_q);
          sat_y_q <= sat_angle(avg_y_q);
        end
        s2_valid_q <= s1_valid_q;

        angle_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          angle_x_q <= sat_x_q;
          angle_y_q <= sat_y_q;
          stale_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.angle_x     = angle_x_q;
  assign bus.angle_y     = angle_y_q;
  assign bus.angle_valid = angle_valid_q;
  assign bus.stale       = stale_q;

endmodule

// File: tb/tb_tilt_angle_filter.sv
// Directed and randomized checks of tilt_angle_filter against a block-level arithmetic model.
module tb_tilt_angle_filter;

  localparam int unsigned Timeout = 1000;
  localparam int          Center  = 135;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tilt_angle_filter_if bus ();

  tilt_angle_filter #(
    .AVG_LOG2      (3),
    .SCALE_SHIFT   (7),
    .CENTER        (8'd135),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  int pulse_cnt  = 0;

  // Model state: samples of the open block, results waiting to appear, idle run length.
  int m_x[$];
  int m_y[$];
  int pd_due[$];
  int pd_x[$];
  int pd_y[$];
  int cyc  = 0;
  int idle = 0;
  logic [7:0] e_ax = 8'd135;
  logic [7:0] e_ay = 8'd135;
  logic       e_valid = 1'b0;
  logic       e_stale = 1'b1;

  function automatic int ref_angle(int block_sum);
    int avg;
    int scaled;
    int a;
    avg    = int'($floor(block_sum / 8.0));
    scaled = int'($floor(avg / 128.0));
    a      = Center + scaled;
    if (a < 0)   a = 0;
    if (a > 255) a = 255;
    return a;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [15:0] x,
                            input logic [15:0] y);
    int sx;
    int sy;
    cyc++;
    e_valid = 1'b0;
    if (r) begin
      m_x.delete(); m_y.delete();
      pd_due.delete(); pd_x.delete(); pd_y.delete();
      idle    = 0;
      e_ax    = 8'(Center);
      e_ay    = 8'(Center);
      e_stale = 1'b1;
    end else begin
      if (v) begin
        idle = 0;
        m_x.push_back(int'($signed(x)));
        m_y.push_back(int'($signed(y)));
        if (m_x.size() == 8) begin
          sx = 0;
          sy = 0;
          foreach (m_x[i]) sx += m_x[i];
          foreach (m_y[i]) sy += m_y[i];
          pd_due.push_back(cyc + 2);
          pd_x.push_back(ref_angle(sx));
          pd_y.push_back(ref_angle(sy));
          m_x.delete();
          m_y.delete();
        end
      end else if (idle < Timeout) begin
        idle++;
        if (idle == Timeout) begin
          m_x.delete(); m_y.delete();
          pd_due.delete(); pd_x.delete(); pd_y.delete();
          e_ax    = 8'(Center);
          e_ay    = 8'(Center);
          e_stale = 1'b1;
        end
      end
      if (pd_due.size() > 0 && pd_due[0] == cyc) begin
        e_ax    = 8'(pd_x.pop_front());
        e_ay    = 8'(pd_y.pop_front());
        void'(pd_due.pop_front());
        e_valid = 1'b1;
        e_stale = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [15:0] x,
                       input logic [15:0] y);
    rst              = r;
    bus.sample_valid = v;
    bus.accel_x      = x;
    bus.accel_y      = y;
    @(posedge clk);
    #1;
    model_step(r, v, x, y);
    if (bus.angle_valid === 1'b1) pulse_cnt++;
    check("angle_x", bus.angle_x, e_ax);
    check("angle_y", bus.angle_y, e_ay);
    check("angle_valid", 8'(bus.angle_valid), 8'(e_valid));
    check("stale", 8'(bus.stale), 8'(e_stale));
  endtask

  task automatic idle_n(input int n);
    repeat (n) cycle(1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic block(input logic [15:0] x, input logic [15:0] y);
    repeat (8) cycle(1'b0, 1'b1, x, y);
  endtask

  function automatic logic [15:0] rand_sample();
    if ($urandom_range(0, 1) == 0) return 16'($urandom);
    return 16'(int'($urandom_range(0, 4000)) - 2000);
  endfunction

  initial begin
    bus.sample_valid = 1'b0;
    bus.accel_x      = '0;
    bus.accel_y      = '0;

    // Reset and quiet period shorter than the watchdog.
    cycle(1'b1, 1'b0, 16'd0, 16'd0);
    cycle(1'b1, 1'b0, 16'd0, 16'd0);
    check("rst_x", bus.angle_x, 8'd135);
    check("rst_stale", 8'(bus.stale), 8'd1);
    idle_n(100);
    check("quiet_y", bus.angle_y, 8'd135);

    // Nominal block: result lands two edges after the final sample.
    block(16'd4096, 16'hE000);
    idle_n(1);
    check("nom_early_valid", 8'(bus.angle_valid), 8'd0);
    idle_n(1);
    check("nom_x", bus.angle_x, 8'd167);
    check("nom_y", bus.angle_y, 8'd71);
    check("nom_valid", 8'(bus.angle_valid), 8'd1);
    check("nom_stale", 8'(bus.stale), 8'd0);
    idle_n(1);
    check("nom_pulse_end", 8'(bus.angle_valid), 8'd0);

    block(16'h7FFF, 16'h8000);
    idle_n(2);
    check("sat_x", bus.angle_x, 8'd255);
    check("sat_y", bus.angle_y, 8'd0);

    repeat (7) cycle(1'b0, 1'b1, 16'd0, 16'd0);
    cycle(1'b0, 1'b1, 16'hFFFF, 16'd0);
    idle_n(2);
    check("round_x", bus.angle_x, 8'd134);
    check("round_y", bus.angle_y, 8'd135);

    // Watchdog: partial block is discarded on expiry.
    block(16'd4096, 16'hE000);
    repeat (3) cycle(1'b0, 1'b1, 16'h7FFF, 16'h7FFF);
    idle_n(Timeout);
    check("wd_stale", 8'(bus.stale), 8'd1);
    check("wd_x", bus.angle_x, 8'd135);
    block(16'd4096, 16'hE000);
    idle_n(2);
    check("wd_after_x", bus.angle_x, 8'd167);
    check("wd_after_y", bus.angle_y, 8'd71);

    // Reset mid-block, then reset right behind a final sample.
    repeat (5) cycle(1'b0, 1'b1, 16'h7FFF, 16'h7FFF);
    cycle(1'b1, 1'b0, 16'd0, 16'd0);
    pulse_cnt = 0;
    block(16'd0, 16'd0);
    idle_n(4);
    check("rstmid_x", bus.angle_x, 8'd135);
    check("rstmid_pulses", 8'(pulse_cnt), 8'd1);
    block(16'h7FFF, 16'h7FFF);
    pulse_cnt = 0;
    cycle(1'b1, 1'b0, 16'd0, 16'd0);
    idle_n(4);
    check("rstlate_pulses", 8'(pulse_cnt), 8'd0);
    check("rstlate_x", bus.angle_x, 8'd135);

    // Continuous samples: two back-to-back blocks each produce a pulse.
    pulse_cnt = 0;
    block(16'd4096, 16'hE000);
    block(16'h7FFF, 16'h8000);
    idle_n(3);
    check("b2b_pulses", 8'(pulse_cnt), 8'd2);

    // Randomized traffic with gaps, occasional resets and watchdog expiries.
    for (int b = 0; b < 60; b++) begin
      int n;
      n = int'($urandom_range(1, 12));
      for (int s = 0; s < n; s++) begin
        cycle(1'b0, 1'b1, rand_sample(), rand_sample());
        if ($urandom_range(0, 2) == 0) idle_n(int'($urandom_range(1, 4)));
      end
      case ($urandom_range(0, 19))
        0: cycle(1'b1, 1'b0, 16'd0, 16'd0);
        1: idle_n(int'(Timeout) + int'($urandom_range(0, 3)));
        2: idle_n(int'(Timeout) - 1);
        default: ;
      endcase
    end
    idle_n(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
